ram_write_sequencer: RTL and testbench

Write-side controller for the 32x4 two-port RAM used on the DE1-SoC board. It turns debounced KEY presses into single-cycle RAM write strobes at an auto-incrementing write address, so the once-per-second read scanner can display the entries. It also provides a bulk clear that zeroes every location, and reports fill level, full and busy status for the HEX displays. It drives the RAM write port (address, data, enable) and runs from the same 50 MHz clock as the rest of the design.

---
 rtl/ram_write_sequencer_if.sv | 13 +
 rtl/ram_write_sequencer.sv | 130 +++++++++++++
 tb/tb_ram_write_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_write_sequencer_if.sv
// RAM write port bundle: address, data and single-cycle write strobe.
// The sequencer drives it through the master modport and the RAM consumes it through the slave modport.
interface ram_write_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] WrAddress;
    logic [DATA_W-1:0] WrData;
    logic              WrEnable;

    modport master (output WrAddress, output WrData, output WrEnable);
    modport slave  (input  WrAddress, input  WrData, input  WrEnable);
endinterface

// File: rtl/ram_write_sequencer.sv
// Write-side controller for the DE1-SoC 32x4 RAM: debounced key presses become
// auto-addressed write strobes, and a bulk clear zeroes every location.
module ram_write_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 32,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     DataIn,
    input  logic                  Store,
    input  logic                  ClearReq,
    ram_write_sequencer_if.master wr,
    output logic [ADDR_W:0]       Count,
    output logic                  Full,
    output logic                  Busy
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic             s_meta_q, s_sync_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q;
    logic              busy_q;

    // Synchronizer and debouncer flops reset to the released (high) level.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            s_meta_q   <= 1'b1;
            s_sync_q   <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            deb_cnt_q  <= '0;
        end else begin
            s_meta_q   <= Store;
            s_sync_q   <= s_meta_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (s_sync_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = s_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign press   = deb_prev_q & ~deb_q;
    assign count_d = (count_q == DEPTH_C) ? count_q : count_q + (ADDR_W + 1)'(1);

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // Count/Full advance on the edge that ends a data strobe.
            if (wr_en_q && !busy_q) begin
                count_q <= count_d;
                full_q  <= (count_d == DEPTH_C);
            end
            case (state_q)
                IDLE: begin
                    if (ClearReq) begin
                        // Address 0 is emitted on entry, so ptr already points at 1.
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        wr_data_q <= '0;
                        ptr_q     <= ADDR_W'(1);
                    end else if (press && !full_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= DataIn;
                        ptr_q     <= ptr_q + ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        ptr_q     <= ptr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr.WrAddress = wr_addr_q;
    assign wr.WrData    = wr_data_q;
    assign wr.WrEnable  = wr_en_q;
    assign Count        = count_q;
    assign Full         = full_q;
    assign Busy         = busy_q;
endmodule

// File: tb/tb_ram_write_sequencer.sv
// Self-checking bench for ram_write_sequencer with a short debounce window;
// expected RAM writes are queued as stimulus is driven and matched against each strobe.
module tb_ram_write_sequencer;
    logic       CLOCK_50;
    logic       Reset;
    logic [3:0] DataIn;
    logic       Store;
    logic       ClearReq;
    logic [5:0] Count;
    logic       Full;
    logic       Busy;

    ram_write_sequencer_if #(.ADDR_W(5), .DATA_W(4)) wr_if ();

    ram_write_sequencer #(
        .ADDR_W(5), .DATA_W(4), .DEPTH(32), .DEB_CYCLES(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .Reset   (Reset),
        .DataIn  (DataIn),
        .Store   (Store),
        .ClearReq(ClearReq),
        .wr      (wr_if.master),
        .Count   (Count),
        .Full    (Full),
        .Busy    (Busy)
    );

    typedef struct {
        logic [4:0] addr;
        logic [3:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  data;
        bit          exp_write;
        logic [4:0]  exp_addr;
        int unsigned exp_count;
        bit          exp_full;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[33];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (Reset === 1'b1 && wr_if.WrEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h expected=no strobe at %0t",
                         wr_if.WrAddress, wr_if.WrData, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_if.WrAddress), 32'(mon_e.addr));
                check("wr_data", 32'(wr_if.WrData), 32'(mon_e.data));
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        Reset    = 1'b0;
        Store    = 1'b1;
        ClearReq = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge CLOCK_50);
        Reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [3:0] d, input bit expect_write, input logic [4:0] exp_addr);
        DataIn = d;
        if (expect_write) exp_q.push_back('{addr: exp_addr, data: d});
        Store = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        Store = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        wait_drain("press_drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(wr_if.WrAddress), 32'd0);
        check({tag, "_data"},  32'(wr_if.WrData),    32'd0);
        check({tag, "_wren"},  32'(wr_if.WrEnable),  32'd0);
        check({tag, "_count"}, 32'(Count),           32'd0);
        check({tag, "_full"},  32'(Full),            32'd0);
        check({tag, "_busy"},  32'(Busy),            32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 33; i++) begin
            vecs[i].data      = 4'(i);
            vecs[i].exp_write = (i < 32);
            vecs[i].exp_addr  = 5'(i);
            vecs[i].exp_count = (i < 32) ? i + 1 : 32;
            vecs[i].exp_full  = (i >= 31);
        end

        Reset = 1'b0; Store = 1'b1; ClearReq = 1'b0; DataIn = 4'h0;
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("in_reset");
        Reset = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check_reset_outputs("idle");
        check("deb_idle", 32'(dut.deb_q), 32'd1);

        // First press: strobe seven edges after Store falls.
        DataIn = 4'hA;
        exp_q.push_back('{addr: 5'd0, data: 4'hA});
        Store = 1'b0;
        n = 0;
        do begin
            @(posedge CLOCK_50);
            n++;
            @(negedge CLOCK_50);
        end while (wr_if.WrEnable !== 1'b1 && n < 20);
        check("press_latency", 32'(n), 32'd7);
        repeat (3) @(negedge CLOCK_50);
        Store = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        wait_drain("first_drain");
        check("count_first", 32'(Count), 32'd1);

        // Bounce shorter than the debounce window, then a clean hold.
        DataIn = 4'h3;
        exp_q.push_back('{addr: 5'd1, data: 4'h3});
        for (int i = 0; i < 10; i++) begin
            Store = i[0];
            repeat (2) @(negedge CLOCK_50);
        end
        Store = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        Store = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        wait_drain("bounce_drain");
        check("count_bounce", 32'(Count), 32'd2);

        // Fill all 32 locations, then one press while full.
        do_reset();
        for (int i = 0; i < 33; i++) begin
            press(vecs[i].data, vecs[i].exp_write, vecs[i].exp_addr);
            check("fill_count", 32'(Count), 32'(vecs[i].exp_count));
            check("fill_full",  32'(Full),  32'(vecs[i].exp_full));
        end

        // Bulk clear from full.
        for (int i = 0; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: 4'h0});
        ClearReq = 1'b1;
        @(negedge CLOCK_50);
        ClearReq = 1'b0;
        check("busy_rise", 32'(Busy), 32'd1);
        n = 0;
        while (Busy === 1'b1 && n < 60) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("busy_cycles", 32'(n), 32'd32);
        wait_drain("clear_drain");
        check("count_cleared", 32'(Count), 32'd0);
        check("full_cleared",  32'(Full),  32'd0);

        press(4'h5, 1'b1, 5'd0);
        check("count_after_clear", 32'(Count), 32'd1);

        // ClearReq in the cycle the press is detected: clear wins.
        DataIn = 4'h7;
        Store = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        ClearReq = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: 4'h0});
        @(negedge CLOCK_50);
        ClearReq = 1'b0;
        n = 0;
        while (exp_q.size() > 22 && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("clear_progress", 32'(exp_q.size()), 32'd22);

        // Reset at clear cycle 10 aborts the clear immediately.
        #1;
        Reset = 1'b0;
        Store = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_clear_reset");
        repeat (3) @(negedge CLOCK_50);
        Reset = 1'b1;
        repeat (15) @(negedge CLOCK_50);
        check("count_post_reset", 32'(Count), 32'd0);
        check("busy_post_reset",  32'(Busy),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
